// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A interrupt-acknowledge sequencer.
package pic_pkg;

  // Acknowledge sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } ack_state_e;

  // Data-bus byte selects handed to the data buffer
  localparam logic [1:0] SEL_CALL = 2'd0;
  localparam logic [1:0] SEL_LO   = 2'd1;
  localparam logic [1:0] SEL_HI   = 2'd2;
  localparam logic [1:0] SEL_V86  = 2'd3;

  // Number of INTA pulses in each processor mode
  localparam logic [1:0] PULSES_8086 = 2'd2;
  localparam logic [1:0] PULSES_8080 = 2'd3;

  // CALL opcode driven by the data buffer on the first 8080 pulse
  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  // Index of the final pulse of a sequence for the given processor mode
  function automatic logic [1:0] last_pulse(input logic upm_8086);
    return upm_8086 ? PULSES_8086 : PULSES_8080;
  endfunction

endpackage

// File: rtl/inta_edge_det.sv
// Registers the synchronised INTA strobe and flags its falling and rising edges.
module inta_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic inta_n,
  output logic inta_fall,
  output logic inta_rise
);

  logic inta_q;
  logic inta_d;

  // Next value of the strobe history is simply the current strobe
  always_comb begin
    inta_d = inta_n;
  end

  // History starts high so a strobe held low through reset is seen as a new fall
  always_ff @(posedge clk) begin
    if (rst) begin
      inta_q <= 1'b1;
    end else begin
      inta_q <= inta_d;
    end
  end

  // Edges compare the live strobe against last cycle's value
  always_comb begin
    inta_fall = inta_q & ~inta_n;
    inta_rise = ~inta_q & inta_n;
  end

endmodule

// File: rtl/cascade_ack_seq.sv
// Sequences the 8259A INTA pulse train: latches the acknowledged level, sets/clears
// the ISR bit, drives the CAS bus as master, and gates vector bytes onto the data bus.
module cascade_ack_seq
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inta_n,
  input  logic       master,
  input  logic       single,
  input  logic       upm_8086,
  input  logic       aeoi,
  input  logic [7:0] slave_map,
  input  logic [2:0] slave_id,
  input  logic       int_valid,
  input  logic [2:0] int_level,
  input  logic [2:0] cas_in,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  output logic       freeze,
  output logic       isr_set,
  output logic       aeoi_clr,
  output logic [2:0] ack_level,
  output logic       data_oe,
  output logic [1:0] data_sel,
  output logic       spurious
);

  logic inta_fall;
  logic inta_rise;

  ack_state_e state_q, state_d;
  logic [1:0] pc_q, pc_d;
  logic [2:0] ack_level_q, ack_level_d;
  logic       spurious_q, spurious_d;
  logic       valid_q, valid_d;
  logic       upm_q, upm_d;
  logic       master_q, master_d;
  logic       single_q, single_d;
  logic       aeoi_q, aeoi_d;
  logic       sel_q, sel_d;
  logic       start_q, start_d;
  logic       p1_rise_q, p1_rise_d;
  logic       done_q, done_d;
  logic       fired_q, fired_d;
  logic       freeze_q, freeze_d;
  logic       isr_set_q, isr_set_d;
  logic       aeoi_clr_q, aeoi_clr_d;
  logic [2:0] cas_out_q, cas_out_d;
  logic       cas_oe_q, cas_oe_d;
  logic       data_oe_q, data_oe_d;
  logic [1:0] data_sel_q, data_sel_d;

  logic       hit;
  logic       prov;
  logic       master_or_single;
  logic       last_rise;
  logic       seq_start;

  inta_edge_det u_edge (
    .clk       (clk),
    .rst       (rst),
    .inta_n    (inta_n),
    .inta_fall (inta_fall),
    .inta_rise (inta_rise)
  );

  // Next-state logic for the pulse sequencer and every registered output
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ack_level_d = ack_level_q;
    spurious_d  = spurious_q;
    valid_d     = valid_q;
    upm_d       = upm_q;
    master_d    = master_q;
    single_d    = single_q;
    aeoi_d      = aeoi_q;
    sel_d       = sel_q;

    master_or_single = master_q | single_q;
    hit  = master_q & ~single_q & slave_map[ack_level_q];
    prov = single_q | (master_q & ~hit) | (~master_q & sel_q);

    seq_start = (state_q == IDLE) & inta_fall;
    last_rise = (state_q == PULSE) & inta_rise & (pc_q == last_pulse(upm_q));

    case (state_q)
      IDLE: begin
        if (inta_fall) begin
          state_d     = PULSE;
          pc_d        = 2'd1;
          upm_d       = upm_8086;
          master_d    = master;
          single_d    = single;
          aeoi_d      = aeoi;
          valid_d     = int_valid;
          ack_level_d = int_valid ? int_level : 3'd7;
          spurious_d  = ~int_valid;
          sel_d       = 1'b0;
        end
      end
      PULSE: begin
        if (inta_rise) begin
          if (pc_q == 2'd1) begin
            sel_d = (cas_in == slave_id);
          end
          if (last_rise) begin
            state_d = IDLE;
            pc_d    = 2'd0;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (inta_fall) begin
          state_d = PULSE;
          pc_d    = pc_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = 2'd0;
      end
    endcase

    start_d   = seq_start;
    p1_rise_d = (state_q == PULSE) & inta_rise & (pc_q == 2'd1);
    done_d    = last_rise;
    fired_d   = seq_start ? 1'b0 : (fired_q | isr_set_q);

    freeze_d  = (state_d != IDLE);

    isr_set_d = valid_q & ((start_q & master_or_single) |
                           (p1_rise_q & ~master_or_single & sel_q));

    aeoi_clr_d = done_q & aeoi_q & fired_q;

    cas_oe_d  = (state_q != IDLE) & ~last_rise & hit;
    cas_out_d = cas_oe_d ? ack_level_q : 3'd0;

    data_oe_d  = 1'b0;
    data_sel_d = SEL_CALL;
    if (state_q == PULSE) begin
      if (upm_q) begin
        if ((pc_q == 2'd2) && prov) begin
          data_oe_d  = 1'b1;
          data_sel_d = SEL_V86;
        end
      end else begin
        case (pc_q)
          2'd1: begin
            if (master_or_single) begin
              data_oe_d  = 1'b1;
              data_sel_d = SEL_CALL;
            end
          end
          2'd2: begin
            if (prov) begin
              data_oe_d  = 1'b1;
              data_sel_d = SEL_LO;
            end
          end
          2'd3: begin
            if (prov) begin
              data_oe_d  = 1'b1;
              data_sel_d = SEL_HI;
            end
          end
          default: begin
            data_oe_d  = 1'b0;
            data_sel_d = SEL_CALL;
          end
        endcase
      end
    end
  end

  // Sequencer state and outputs; reset aborts any sequence without an AEOI clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= 2'd0;
      ack_level_q <= 3'd0;
      spurious_q  <= 1'b0;
      valid_q     <= 1'b0;
      upm_q       <= 1'b0;
      master_q    <= 1'b0;
      single_q    <= 1'b0;
      aeoi_q      <= 1'b0;
      sel_q       <= 1'b0;
      start_q     <= 1'b0;
      p1_rise_q   <= 1'b0;
      done_q      <= 1'b0;
      fired_q     <= 1'b0;
      freeze_q    <= 1'b0;
      isr_set_q   <= 1'b0;
      aeoi_clr_q  <= 1'b0;
      cas_out_q   <= 3'd0;
      cas_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      data_sel_q  <= SEL_CALL;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ack_level_q <= ack_level_d;
      spurious_q  <= spurious_d;
      valid_q     <= valid_d;
      upm_q       <= upm_d;
      master_q    <= master_d;
      single_q    <= single_d;
      aeoi_q      <= aeoi_d;
      sel_q       <= sel_d;
      start_q     <= start_d;
      p1_rise_q   <= p1_rise_d;
      done_q      <= done_d;
      fired_q     <= fired_d;
      freeze_q    <= freeze_d;
      isr_set_q   <= isr_set_d;
      aeoi_clr_q  <= aeoi_clr_d;
      cas_out_q   <= cas_out_d;
      cas_oe_q    <= cas_oe_d;
      data_oe_q   <= data_oe_d;
      data_sel_q  <= data_sel_d;
    end
  end

  // Outputs come straight from their flops
  always_comb begin
    cas_out   = cas_out_q;
    cas_oe    = cas_oe_q;
    freeze    = freeze_q;
    isr_set   = isr_set_q;
    aeoi_clr  = aeoi_clr_q;
    ack_level = ack_level_q;
    data_oe   = data_oe_q;
    data_sel  = data_sel_q;
    spurious  = spurious_q;
  end

endmodule
